// File: rtl/fifo_bank.sv
// Register-bank FIFO with non-power-of-two depth, occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_bank #(
    parameter int bits       = 8,
    parameter int depth      = 10,
    parameter int afull_thr  = depth - 2,
    parameter int aempty_thr = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [bits-1:0]            wr_data,
    input  logic                       rd_en,
    output logic [bits-1:0]            rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(depth+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int PW = $clog2(depth);
    localparam int CW = $clog2(depth + 1);

    localparam logic [PW-1:0] LAST   = PW'(depth - 1);
    localparam logic [CW-1:0] FULL_C = CW'(depth);
    localparam logic [CW-1:0] AF_C   = CW'(afull_thr);
    localparam logic [CW-1:0] AE_C   = CW'(aempty_thr);

    logic [bits-1:0] mem_q [depth];
    logic [bits-1:0] mem_d [depth];

    logic [PW-1:0]   wp_q, wp_d;
    logic [PW-1:0]   rp_q, rp_d;
    logic [CW-1:0]   count_q, count_d;
    logic [bits-1:0] rd_data_q, rd_data_d;
    logic            rd_valid_q, rd_valid_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;

    logic            wr_acc;
    logic            rd_acc;
    logic [depth-1:0] we_oh;

    assign empty        = (count_q == '0);
    assign full         = (count_q == FULL_C);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);

    assign rd_acc = rd_en && !empty;
    // At full a concurrent read frees the slot, so the write still goes in.
    assign wr_acc = wr_en && (!full || rd_acc);

    always_comb begin
        we_oh = '0;
        for (int i = 0; i < depth; i++) begin
            we_oh[i] = wr_acc && (wp_q == PW'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < depth; i++) begin
            mem_d[i] = we_oh[i] ? wr_data : mem_q[i];
        end
    end

    always_comb begin
        wp_d       = wp_q;
        rp_d       = rp_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        if (wr_acc) begin
            wp_d = (wp_q == LAST) ? '0 : wp_q + 1'b1;
        end

        if (rd_acc) begin
            rp_d       = (rp_q == LAST) ? '0 : rp_q + 1'b1;
            rd_data_d  = mem_q[rp_q];
            rd_valid_d = 1'b1;
        end

        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end
    end

    // A new error outranks a same-cycle clear.
    always_comb begin
        ovf_d = (ovf_q && !clr_err) || (wr_en && !wr_acc);
        unf_d = (unf_q && !clr_err) || (rd_en && empty);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < depth; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule
